// File: rtl/lsu_pkg.sv
// Shared types and constants for the LDUR/STUR load/store initiator.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } lsu_state_e;

    // Byte address to 64-bit word index.
    localparam int unsigned WORD_SHIFT = 3;
    localparam int unsigned LAT_CNT_W  = 4;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus data-memory pins of the load/store initiator.
interface lsu_mem_master_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);

    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_is_store, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport slave (
        output req_valid, req_is_store, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );

endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator toward a word-indexed data memory.
// Define MISALIGN_CHECK_EN to reject addresses with req_addr[2:0] != 0.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned MEMSIZE = 64,
    parameter int unsigned RD_LAT  = 1
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_master_if.master bus
);

    localparam logic [LAT_CNT_W-1:0] LatInit = LAT_CNT_W'(RD_LAT);

    lsu_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic              ready;
    logic              accept;
    logic              wr_on;
    logic              rd_on;
    logic              resp_on;

    assign req_idx = bus.req_addr >> WORD_SHIFT;

`ifdef MISALIGN_CHECK_EN
    assign req_err = (req_idx >= ADDR_W'(MEMSIZE)) || (bus.req_addr[WORD_SHIFT-1:0] != '0);
`else
    assign req_err = req_idx >= ADDR_W'(MEMSIZE);
`endif

    assign ready  = (state_q == IDLE) && !rst;
    assign accept = bus.req_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_idx;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    cnt_d   = LatInit;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_is_store) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: state_d = RESP;
            READ: begin
                // Last READ cycle: sample memory data as the FSM leaves.
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while rst is held, not just after the reset edge.
    assign wr_on   = !rst && (state_q == WRITE);
    assign rd_on   = !rst && (state_q == READ);
    assign resp_on = !rst && (state_q == RESP);

    assign bus.req_ready  = ready;
    assign bus.busy       = !rst && (state_q != IDLE);
    assign bus.mem_write  = wr_on;
    assign bus.mem_read   = rd_on;
    assign bus.mem_addr   = (wr_on || rd_on) ? addr_q : '0;
    assign bus.mem_wdata  = wr_on ? wdata_q : '0;
    assign bus.resp_valid = resp_on;
    assign bus.resp_err   = resp_on && err_q;
    assign bus.resp_rdata = resp_on ? rdata_q : '0;

endmodule
